// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI target endpoint.
package spi_pkg;

    // Frame-level states of the target controller.
    typedef enum logic [1:0] {
        ST_RESYNC,
        ST_IDLE,
        ST_ACTIVE,
        ST_DONE
    } spi_target_state_t;

    // Byte returned on miso when there is nothing queued to send.
    localparam logic [7:0] SPI_FILL_DEFAULT = 8'hFF;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-stage synchronizer for one asynchronous pin, with edge detection
// on the synchronized level against a one-cycle delayed copy.
// STAGES must be at least 2.
module spi_sync_edge #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
)(
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;
    logic              dly_q;

    assign sync_d[0] = d;

    generate
        for (genvar gi = 1; gi < STAGES; gi++) begin : g_stage
            assign sync_d[gi] = sync_q[gi-1];
        end
    endgenerate

    // Shift the pin through the chain and keep a delayed copy of the output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= {STAGES{RST_VAL}};
            dly_q  <= RST_VAL;
        end else begin
            sync_q <= sync_d;
            dly_q  <= sync_q[STAGES-1];
        end
    end

    assign level = sync_q[STAGES-1];
    assign rise  =  sync_q[STAGES-1] & ~dly_q;
    assign fall  = ~sync_q[STAGES-1] &  dly_q;

endmodule

// File: rtl/spi_target.sv
// SPI responder (mode 0, MSB first) running entirely in the clk domain.
// Received bytes are written to an RX FIFO; bytes popped from a show-ahead
// TX FIFO are returned on miso, or FILL when that FIFO is empty.
module spi_target
    import spi_pkg::*;
#(
    parameter int              DATA        = 8,
    parameter int              SYNC_STAGES = 2,
    parameter logic [DATA-1:0] FILL        = SPI_FILL_DEFAULT
)(
    input  logic            clk,
    input  logic            rst,
    input  logic            scsn,
    input  logic            sclk,
    input  logic            mosi,
    output logic            miso,
    output logic            miso_oe,
    output logic [DATA-1:0] wdata,
    output logic            wr,
    input  logic            full,
    input  logic [DATA-1:0] rdata,
    output logic            rd,
    input  logic            empty,
    output logic            busy,
    output logic            frame_done,
    output logic [15:0]     bytecount,
    output logic            overflow,
    output logic            underflow,
    output logic            abort,
    input  logic            clr_flags
);

    localparam int            BW       = $clog2(DATA);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA - 1);

    logic scsn_lvl, scsn_rise, scsn_fall;
    logic sclk_lvl, sclk_rise, sclk_fall;
    logic mosi_lvl, mosi_rise, mosi_fall;

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_scsn_sync (
        .clk(clk), .rst(rst), .d(scsn),
        .level(scsn_lvl), .rise(scsn_rise), .fall(scsn_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk_sync (
        .clk(clk), .rst(rst), .d(sclk),
        .level(sclk_lvl), .rise(sclk_rise), .fall(sclk_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_mosi_sync (
        .clk(clk), .rst(rst), .d(mosi),
        .level(mosi_lvl), .rise(mosi_rise), .fall(mosi_fall)
    );

    // Only the level of mosi and the edges of sclk are meaningful here.
    logic unused_sync;
    assign unused_sync = ^{sclk_lvl, mosi_rise, mosi_fall};

    spi_target_state_t state_q;
    logic [BW-1:0]     bitcnt_q;
    logic [DATA-2:0]   rxshift_q;
    // The MSB of the outgoing byte lives in miso_q; only the remaining bits are kept here.
    logic [DATA-2:0]   txshift_q;
    logic              miso_q, miso_oe_q, wr_q, rd_q, busy_q, frame_done_q;
    logic [DATA-1:0]   wdata_q;
    logic [15:0]       bytecount_q;
    logic              overflow_q, underflow_q, abort_q;

    logic [DATA-1:0] tx_load;
    logic [DATA-1:0] rx_byte;

    assign tx_load = empty ? FILL : rdata;
    assign rx_byte = {rxshift_q, mosi_lvl};

    // Frame controller: state, shift registers, FIFO strobes and sticky flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_RESYNC;
            bitcnt_q     <= '0;
            rxshift_q    <= '0;
            txshift_q    <= '0;
            miso_q       <= 1'b1;
            miso_oe_q    <= 1'b0;
            wr_q         <= 1'b0;
            rd_q         <= 1'b0;
            wdata_q      <= '0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            bytecount_q  <= '0;
            overflow_q   <= 1'b0;
            underflow_q  <= 1'b0;
            abort_q      <= 1'b0;
        end else begin
            wr_q         <= 1'b0;
            rd_q         <= 1'b0;
            frame_done_q <= 1'b0;
            // Clear first so that any set later in this block wins.
            if (clr_flags) begin
                overflow_q  <= 1'b0;
                underflow_q <= 1'b0;
                abort_q     <= 1'b0;
            end
            case (state_q)
                ST_RESYNC: begin
                    // Never join a frame that was already running when reset released.
                    if (scsn_lvl) state_q <= ST_IDLE;
                end
                ST_IDLE: begin
                    if (scsn_fall) begin
                        bytecount_q <= '0;
                        bitcnt_q    <= '0;
                        txshift_q   <= tx_load[DATA-2:0];
                        miso_q      <= tx_load[DATA-1];
                        if (empty) underflow_q <= 1'b1;
                        else       rd_q        <= 1'b1;
                        miso_oe_q   <= 1'b1;
                        busy_q      <= 1'b1;
                        state_q     <= ST_ACTIVE;
                    end
                end
                ST_ACTIVE: begin
                    if (scsn_rise) begin
                        // Chip-select release overrides any simultaneous sclk edge.
                        if (bitcnt_q != '0) abort_q <= 1'b1;
                        miso_oe_q    <= 1'b0;
                        miso_q       <= 1'b1;
                        frame_done_q <= 1'b1;
                        state_q      <= ST_DONE;
                    end else if (sclk_rise) begin
                        rxshift_q <= rx_byte[DATA-2:0];
                        if (bitcnt_q == LAST_BIT) begin
                            bitcnt_q <= '0;
                            if (bytecount_q != 16'hFFFF) bytecount_q <= bytecount_q + 16'd1;
                            if (!full) begin
                                wdata_q <= rx_byte;
                                wr_q    <= 1'b1;
                            end else begin
                                overflow_q <= 1'b1;
                            end
                        end else begin
                            bitcnt_q <= bitcnt_q + 1'b1;
                        end
                    end else if (sclk_fall) begin
                        if (bitcnt_q != '0) begin
                            miso_q    <= txshift_q[DATA-2];
                            txshift_q <= {txshift_q[DATA-3:0], 1'b0};
                        end else begin
                            txshift_q <= tx_load[DATA-2:0];
                            miso_q    <= tx_load[DATA-1];
                            if (empty) underflow_q <= 1'b1;
                            else       rd_q        <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_RESYNC;
            endcase
        end
    end

    assign miso       = miso_q;
    assign miso_oe    = miso_oe_q;
    assign wdata      = wdata_q;
    assign wr         = wr_q;
    assign rd         = rd_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;
    assign bytecount  = bytecount_q;
    assign overflow   = overflow_q;
    assign underflow  = underflow_q;
    assign abort      = abort_q;

endmodule

// File: tb/tb_spi_target.sv
// Self-checking bench for spi_target: acts as the SPI initiator and as both
// FIFOs, and predicts each frame from the byte-level rules of the endpoint.
module tb_spi_target;

    localparam logic [7:0] FILL_B = 8'hFF;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        scsn = 1'b1, sclk = 1'b0, mosi = 1'b0;
    logic        full = 1'b0, empty = 1'b1, clr_flags = 1'b0;
    logic [7:0]  rdata = 8'h00;
    logic        miso, miso_oe, wr, rd, busy, frame_done;
    logic        overflow, underflow, abort;
    logic [7:0]  wdata;
    logic [15:0] bytecount;

    spi_target dut (
        .clk(clk), .rst(rst), .scsn(scsn), .sclk(sclk), .mosi(mosi),
        .miso(miso), .miso_oe(miso_oe), .wdata(wdata), .wr(wr), .full(full),
        .rdata(rdata), .rd(rd), .empty(empty), .busy(busy),
        .frame_done(frame_done), .bytecount(bytecount), .overflow(overflow),
        .underflow(underflow), .abort(abort), .clr_flags(clr_flags)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Environment state: TX FIFO contents, bytes to send, observed activity.
    logic [7:0]  tx_q[$];
    logic [7:0]  tx_snap[$];
    logic [7:0]  mo_q[$];
    logic [63:0] wr_vec, miso_vec;
    int          wr_cnt, rd_cnt, fd_cnt;
    int          full_byte  = -1;
    int          clr_at_bit = -1;
    bit          chk_timing = 0;

    // Expected frame results.
    logic [63:0] exp_wr_vec, exp_miso_vec;
    int          exp_wr_cnt, exp_rd, exp_bc;
    logic        exp_uf, exp_of, exp_ab;

    logic prev_wr = 1'b0, prev_rd = 1'b0;

    // FIFO models and strobe logging, sampled just after each active edge.
    always @(posedge clk) begin
        #1;
        if (wr) begin
            wr_vec = {wr_vec[55:0], wdata};
            wr_cnt++;
        end
        if (rd) begin
            rd_cnt++;
            if (tx_q.size() > 0) void'(tx_q.pop_front());
        end
        if (frame_done) fd_cnt++;
        if ((wr && prev_wr) || (rd && prev_rd)) begin
            errors++;
            $display("FAIL strobe_width: wr=%0b rd=%0b high for two cycles, required single pulses", wr, rd);
        end
        prev_wr = wr;
        prev_rd = rd;
        if (tx_q.size() > 0) begin
            rdata = tx_q[0];
            empty = 1'b0;
        end else begin
            rdata = 8'h00;
            empty = 1'b1;
        end
    end

    task automatic clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Byte-level reference: what one frame of nbits should produce.
    task automatic predict(input int nbits);
        int nb;
        int tl;
        logic [7:0] t;
        nb = nbits / 8;
        tl = tx_snap.size();
        exp_wr_vec = '0;
        exp_wr_cnt = 0;
        exp_miso_vec = '0;
        for (int k = 0; k < nb; k++) begin
            if (k != full_byte) begin
                exp_wr_vec = {exp_wr_vec[55:0], mo_q[k]};
                exp_wr_cnt++;
            end
        end
        for (int b = 0; b < nbits; b++) begin
            t = (b / 8 < tl) ? tx_snap[b / 8] : FILL_B;
            exp_miso_vec = {exp_miso_vec[62:0], t[7 - (b % 8)]};
        end
        // One load at frame start plus one at every byte boundary fall.
        exp_rd = (nb + 1 < tl) ? nb + 1 : tl;
        exp_bc = nb;
        exp_uf = (nb + 1 > tl);
        exp_of = (full_byte >= 0) && (full_byte < nb);
        exp_ab = (nbits % 8) != 0;
    endtask

    // Mode-0 initiator: 6 clk per sclk phase, miso sampled just before each rise.
    task automatic spi_frame(input int nbits);
        logic [7:0] cur;
        int k;
        clr_flags = 1'b1;
        clks(1);
        clr_flags = 1'b0;
        tx_snap = tx_q;
        wr_vec = '0; miso_vec = '0;
        wr_cnt = 0; rd_cnt = 0; fd_cnt = 0;
        clks(3);
        scsn = 1'b0;
        if (chk_timing) begin
            clks(2);
            checks++;
            if (miso_oe !== 1'b0)
                $display("FAIL oe_early: miso_oe=%0b two clk after scsn fall, required 0", miso_oe);
            if (miso_oe !== 1'b0) errors++;
            clks(1);
            checks++;
            if (miso_oe !== 1'b1 || busy !== 1'b1) begin
                errors++;
                $display("FAIL oe_latency: miso_oe=%0b busy=%0b three clk after scsn fall, required 1/1", miso_oe, busy);
            end
            clks(3);
        end else begin
            clks(6);
        end
        for (int b = 0; b < nbits; b++) begin
            k = b / 8;
            cur = mo_q[k];
            full = (k == full_byte);
            mosi = cur[7 - (b % 8)];
            clks(6);
            miso_vec = {miso_vec[62:0], miso};
            sclk = 1'b1;
            if (b == clr_at_bit) begin
                // Lands on the edge that registers this rise's result.
                clks(2);
                clr_flags = 1'b1;
                clks(1);
                clr_flags = 1'b0;
                clks(3);
            end else begin
                clks(6);
            end
            sclk = 1'b0;
        end
        clks(6);
        full = 1'b0;
        scsn = 1'b1;
        clks(10);
    endtask

    task automatic load_frame(input int ntx, input int nmo);
        tx_q.delete();
        mo_q.delete();
        for (int i = 0; i < ntx; i++) tx_q.push_back(8'($urandom));
        for (int i = 0; i < nmo; i++) mo_q.push_back(8'($urandom));
        clks(2);
    endtask

    task automatic test_reset();
        clks(3);
        checks++;
        if (miso !== 1'b1 || miso_oe !== 1'b0 || wr !== 1'b0 || rd !== 1'b0 || wdata !== 8'h00 ||
            busy !== 1'b0 || frame_done !== 1'b0 || bytecount !== 16'h0000 ||
            overflow !== 1'b0 || underflow !== 1'b0 || abort !== 1'b0) begin
            errors++;
            $display("FAIL reset_values: miso=%0b oe=%0b wr=%0b rd=%0b wdata=%h busy=%0b fd=%0b bc=%0d of=%0b uf=%0b ab=%0b, required 1 0 0 0 00 0 0 0 0 0 0",
                     miso, miso_oe, wr, rd, wdata, busy, frame_done, bytecount, overflow, underflow, abort);
        end
        rst = 1'b0;
        clks(6);
    endtask

    task automatic test_basic();
        tx_q = '{8'h5A, 8'hC3};
        mo_q = '{8'hA5, 8'h3C};
        full_byte = -1;
        clks(2);
        chk_timing = 1;
        spi_frame(16);
        chk_timing = 0;
        predict(16);
        checks++;
        if (wr_cnt !== 2 || wr_vec[15:0] !== 16'hA53C) begin
            errors++;
            $display("FAIL basic_wr: %0d writes data %h, required 2 writes data a53c", wr_cnt, wr_vec[15:0]);
        end
        checks++;
        if (miso_vec[15:0] !== 16'h5AC3) begin
            errors++;
            $display("FAIL basic_miso: got %h, required 5ac3", miso_vec[15:0]);
        end
        checks++;
        if (rd_cnt !== 2 || bytecount !== 16'd2 || fd_cnt !== 1) begin
            errors++;
            $display("FAIL basic_counts: rd=%0d bytecount=%0d frame_done=%0d, required 2 2 1", rd_cnt, bytecount, fd_cnt);
        end
        checks++;
        if (abort !== exp_ab || overflow !== exp_of || underflow !== exp_uf) begin
            errors++;
            $display("FAIL basic_flags: ab=%0b of=%0b uf=%0b, required %0b %0b %0b", abort, overflow, underflow, exp_ab, exp_of, exp_uf);
        end
    endtask

    task automatic test_underflow();
        tx_q.delete();
        mo_q = '{8'hA5, 8'h3C};
        full_byte = -1;
        clks(2);
        spi_frame(16);
        predict(16);
        checks++;
        if (miso_vec[15:0] !== exp_miso_vec[15:0] || rd_cnt !== 0 || underflow !== 1'b1) begin
            errors++;
            $display("FAIL underflow: miso=%h rd=%0d uf=%0b, required %h 0 1", miso_vec[15:0], rd_cnt, underflow, exp_miso_vec[15:0]);
        end
        checks++;
        if (wr_cnt !== exp_wr_cnt || wr_vec !== exp_wr_vec) begin
            errors++;
            $display("FAIL underflow_wr: %0d writes %h, required %0d writes %h", wr_cnt, wr_vec, exp_wr_cnt, exp_wr_vec);
        end
    endtask

    task automatic test_overflow();
        load_frame(3, 2);
        mo_q = '{8'hA5, 8'h3C};
        full_byte = 1;
        spi_frame(16);
        predict(16);
        full_byte = -1;
        checks++;
        if (wr_cnt !== 1 || wr_vec[7:0] !== 8'hA5 || overflow !== 1'b1 || bytecount !== 16'd2) begin
            errors++;
            $display("FAIL overflow: writes=%0d last=%h of=%0b bc=%0d, required 1 a5 1 2", wr_cnt, wr_vec[7:0], overflow, bytecount);
        end
    endtask

    task automatic test_abort();
        load_frame(2, 2);
        full_byte = -1;
        spi_frame(12);
        predict(12);
        checks++;
        if (wr_cnt !== 1 || wr_vec[7:0] !== mo_q[0] || abort !== 1'b1 || bytecount !== 16'd1) begin
            errors++;
            $display("FAIL abort: writes=%0d data=%h ab=%0b bc=%0d, required 1 %h 1 1", wr_cnt, wr_vec[7:0], abort, bytecount, mo_q[0]);
        end
        checks++;
        if (miso_vec[11:0] !== exp_miso_vec[11:0] || rd_cnt !== exp_rd || fd_cnt !== 1) begin
            errors++;
            $display("FAIL abort_tx: miso=%h rd=%0d fd=%0d, required %h %0d 1", miso_vec[11:0], rd_cnt, fd_cnt, exp_miso_vec[11:0], exp_rd);
        end
    endtask

    task automatic test_random();
        int nbits;
        for (int it = 0; it < 6; it++) begin
            nbits = int'($urandom_range(1, 28));
            load_frame(int'($urandom_range(0, 3)), (nbits + 7) / 8);
            full_byte = int'($urandom_range(0, 3)) - 1;
            spi_frame(nbits);
            predict(nbits);
            checks++;
            if (wr_cnt !== exp_wr_cnt || wr_vec !== exp_wr_vec || miso_vec !== exp_miso_vec) begin
                errors++;
                $display("FAIL random%0d_data: wr %0d/%h miso %h, required wr %0d/%h miso %h",
                         it, wr_cnt, wr_vec, miso_vec, exp_wr_cnt, exp_wr_vec, exp_miso_vec);
            end
            checks++;
            if (rd_cnt !== exp_rd || bytecount !== 16'(exp_bc) || fd_cnt !== 1 ||
                underflow !== exp_uf || overflow !== exp_of || abort !== exp_ab) begin
                errors++;
                $display("FAIL random%0d_status: rd=%0d bc=%0d fd=%0d uf=%0b of=%0b ab=%0b, required %0d %0d 1 %0b %0b %0b",
                         it, rd_cnt, bytecount, fd_cnt, underflow, overflow, abort, exp_rd, exp_bc, exp_uf, exp_of, exp_ab);
            end
        end
        full_byte = -1;
    endtask

    task automatic test_reset_mid_frame();
        tx_q.delete();
        clks(3);
        scsn = 1'b0;
        clks(6);
        for (int b = 0; b < 4; b++) begin
            mosi = 1'b1;
            clks(6);
            sclk = 1'b1;
            clks(6);
            sclk = 1'b0;
        end
        rst = 1'b1;
        clks(2);
        checks++;
        if (miso !== 1'b1 || miso_oe !== 1'b0 || busy !== 1'b0 || bytecount !== 16'd0 ||
            underflow !== 1'b0 || wr !== 1'b0 || rd !== 1'b0) begin
            errors++;
            $display("FAIL midreset_values: miso=%0b oe=%0b busy=%0b bc=%0d uf=%0b wr=%0b rd=%0b, required 1 0 0 0 0 0 0",
                     miso, miso_oe, busy, bytecount, underflow, wr, rd);
        end
        tx_q = '{8'h81, 8'h7E};
        wr_cnt = 0;
        rd_cnt = 0;
        rst = 1'b0;
        clks(3);
        for (int b = 0; b < 10; b++) begin
            mosi = b[0];
            clks(6);
            sclk = 1'b1;
            clks(6);
            sclk = 1'b0;
        end
        clks(6);
        checks++;
        if (wr_cnt !== 0 || rd_cnt !== 0 || busy !== 1'b0 || miso_oe !== 1'b0) begin
            errors++;
            $display("FAIL midreset_quiet: wr=%0d rd=%0d busy=%0b oe=%0b, required 0 0 0 0", wr_cnt, rd_cnt, busy, miso_oe);
        end
        scsn = 1'b1;
        clks(6);
        mo_q = '{8'h96, 8'h0F};
        full_byte = -1;
        spi_frame(16);
        predict(16);
        checks++;
        if (wr_cnt !== 2 || wr_vec[15:0] !== 16'h960F || miso_vec[15:0] !== 16'h817E || rd_cnt !== 2) begin
            errors++;
            $display("FAIL midreset_frame: wr=%0d/%h miso=%h rd=%0d, required 2/960f 817e 2", wr_cnt, wr_vec[15:0], miso_vec[15:0], rd_cnt);
        end
    endtask

    task automatic test_clr_collision();
        load_frame(2, 1);
        full_byte = 0;
        clr_at_bit = 7;
        spi_frame(8);
        full_byte = -1;
        clr_at_bit = -1;
        checks++;
        if (overflow !== 1'b1 || wr_cnt !== 0) begin
            errors++;
            $display("FAIL clr_collision: of=%0b writes=%0d, required 1 0", overflow, wr_cnt);
        end
        clr_flags = 1'b1;
        clks(1);
        clr_flags = 1'b0;
        clks(1);
        checks++;
        if (overflow !== 1'b0) begin
            errors++;
            $display("FAIL clr_after: of=%0b, required 0", overflow);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_underflow();
        test_overflow();
        test_abort();
        test_random();
        test_reset_mid_frame();
        test_clr_collision();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_target.md
# spi_target

SPI responder (CPOL=0, CPHA=0, MSB first) for the far end of the link driven by our SPI initiator. It samples `scsn`/`sclk`/`mosi` in the local `clk` domain through synchronizers. Each byte received on `mosi` is pushed into an RX FIFO, and bytes popped from a TX FIFO are returned on `miso`. It is used in loopback benches and as the device-side endpoint in FPGA-to-FPGA links.

## Interface
- `DATA`, 8: bits per byte.
- `SYNC_STAGES`, 2: synchronizer depth on `scsn`, `sclk`, `mosi`; must be ≥ 2.
- `FILL`, 8'hFF: byte shifted out when the TX FIFO is empty.

Ports:
- `clk` in 1: system clock.
- `rst` in 1: reset, asynchronous, active-high.
- `scsn` in 1: chip select, active-low.
- `sclk` in 1: SPI clock; each phase must be ≥ SYNC_STAGES+1 `clk` periods (≤ clk/6 at default).
- `mosi` in 1: serial data in.
- `miso` out 1: serial data out, registered.
- `miso_oe` out 1: tri-state enable, high while a frame is active.
- `wdata` out DATA: RX byte to FIFO.
- `wr` out 1: RX FIFO write strobe, 1-cycle pulse.
- `full` in 1: RX FIFO full.
- `rdata` in DATA: TX FIFO head (show-ahead, valid while `!empty`).
- `rd` out 1: TX FIFO pop strobe, 1-cycle pulse.
- `empty` in 1: TX FIFO empty.
- `busy` out 1: frame in progress.
- `frame_done` out 1: 1-cycle pulse at frame end.
- `bytecount` out 16: complete bytes received in the last or current frame; saturates at 16'hFFFF.
- `overflow`, `underflow`, `abort` out 1 each: sticky error flags.
- `clr_flags` in 1: clears the sticky flags.

## Operation
- Each input passes through a SYNC_STAGES-deep synchronizer plus one delay flop.
  - Edge detect compares the synchronizer output with the delayed copy.
  - On reset, the `scsn` synchronizer loads 0, `sclk` loads 0, `mosi` loads 0.
- FSM states and transitions:
  - `ST_RESYNC` (reset state): wait until synchronized `scsn` = 1, then go to `ST_IDLE`. This prevents joining a frame mid-way after reset.
  - `ST_IDLE`: on a synchronized `scsn` fall:
    - clear `bytecount` and `bitcnt`;
    - load `txshift`: `rdata` with `rd`=1 if `!empty`, else `FILL` and set `underflow`;
    - go to `ST_ACTIVE`.
  - `ST_ACTIVE`, on an `sclk` rise:
    - `rxshift <= {rxshift[DATA-2:0], mosi_s}`; `bitcnt++`.
    - On the DATA-th bit, `bitcnt` wraps to 0 and `bytecount++`.
    - If `!full`: `wdata` = assembled byte, `wr`=1. Else drop the byte and set `overflow`.
  - `ST_ACTIVE`, on an `sclk` fall:
    - if `bitcnt` ≠ 0, shift `txshift` left;
    - if `bitcnt` = 0 (byte boundary), reload `txshift` from the FIFO or `FILL` using the `ST_IDLE` rules.
  - `ST_ACTIVE`, on a synchronized `scsn` rise: if `bitcnt` ≠ 0, discard the partial byte and set `abort`; then go to `ST_DONE`.
  - `ST_DONE`: `frame_done`=1 for one cycle, then go to `ST_IDLE`.
- `miso` = `txshift[DATA-1]`, registered.
- `miso_oe` = 1 in `ST_ACTIVE`; `miso` = 1 otherwise.
- `busy` = 1 in `ST_ACTIVE` and `ST_DONE`.
- `bytecount` holds its value after the frame until the next `scsn` fall.
- Sticky flags: if a set and `clr_flags` occur in the same cycle, the set wins.
- `sclk` edges while `scsn` is high are ignored.
- An `sclk` edge in the same cycle as the `scsn` rise: the `scsn` rise takes precedence and the edge is ignored.

## Timing
- Reset values:
  - `miso`=1, `miso_oe`=0, `wr`=0, `rd`=0, `wdata`=0;
  - `busy`=0, `frame_done`=0, `bytecount`=0;
  - all flags 0; state `ST_RESYNC`.
- Let edge 0 be the first `clk` edge that samples a pin transition. The resulting action registers at edge SYNC_STAGES; this applies to `wr`, `rd`, the `miso` update and the `frame_done` entry path.
- Consequences at the pins:
  - `miso` changes SYNC_STAGES+1 clk after an `sclk` fall, which satisfies initiator hold.
  - The first bit is valid SYNC_STAGES+1 clk after `scsn` falls; the initiator must allow this before the first `sclk` rise.
- `rd` and `wr` are never high for more than one consecutive cycle. At most one `rd` per byte and one `wr` per byte.

## Structure
- Package `spi_pkg` holds:
  - the state typedef `spi_target_state_t` (`ST_RESYNC`, `ST_IDLE`, `ST_ACTIVE`, `ST_DONE`);
  - the localparam `SPI_FILL_DEFAULT`.
- Sub-module `spi_sync_edge`: a SYNC_STAGES synchronizer with reset value parameter. Outputs are `level`, `rise`, `fall`. It is instantiated three times.

## Test plan
- Frame of bytes 8'hA5, 8'h3C, TX FIFO holding 8'h5A, 8'hC3 → `wr` pulses with `wdata` 8'hA5 then 8'h3C; `miso` bits 0101_1010 then 1100_0011; `rd` pulses twice; `bytecount`=2; `frame_done` pulses once.
- Same frame with TX FIFO empty → `miso` all 1 (8'hFF ×2); `underflow`=1; no `rd`.
- `full`=1 during the second byte → one `wr` only; `overflow`=1; `bytecount`=2.
- `scsn` raised after 12 bits → one `wr` (first byte); `abort`=1; `bytecount`=1.
- Reset asserted mid-byte with `scsn` held low, then released → outputs at reset values; no `wr` or `rd` until `scsn` goes high and a new frame starts, which is then received correctly.
- `clr_flags` pulsed in the same cycle an `overflow` event occurs → `overflow` stays 1; the next `clr_flags` clears it to 0.
